// File: rtl/display_scan_ctrl.sv
// ---------------------------------------------------------------------------
// display_scan_ctrl
//
// Drives the 4-digit multiplexed 7-segment display. A binary value is
// accepted through a one-cycle LOAD handshake and converted to BCD by a
// sequential shift-add-3 engine. The finished digits are committed in a
// single cycle, and a free-running scan scheduler walks the digit slots.
// Each slot starts with an anti-ghosting blanking interval.
//
// Optional feature (compile-time macro DISPLAY_DP_EN):
//   When this macro is defined, the DP_MASK[3:0] input is added. Bit 3 is the
//   thousands digit. The dp bit (segment byte bit 0) of a displayed digit is
//   then driven from ~DP_MASK. When the macro is undefined, the port does not
//   exist and dp is always off.
//
// Ports:
//   CLK      in   1      system clock
//   RST      in   1      synchronous active-high reset
//   VALUE    in   BIN_W  binary value to display (max displayable 9999)
//   LOAD     in   1      one-cycle request to convert VALUE
//   BUSY     out  1      conversion in progress
//   OVF      out  1      last committed VALUE was greater than 9999
//   DIG_EN   in   4      per-digit enable, bit3 = thousands, bit0 = units
//   LZB      in   1      leading-zero blanking enable
//   DP_MASK  in   4      decimal-point mask (only with DISPLAY_DP_EN)
//   DISPLAY  out  16     {seg a..g,dp ; anodes[7:0]}, all active-low
// ---------------------------------------------------------------------------
module display_scan_ctrl #(
    parameter int BIN_W     = 14,
    parameter int SLOT_CYC  = 41667,
    parameter int BLANK_CYC = 500
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [BIN_W-1:0] VALUE,
    input  logic             LOAD,
    output logic             BUSY,
    output logic             OVF,
    input  logic [3:0]       DIG_EN,
    input  logic             LZB,
`ifdef DISPLAY_DP_EN
    input  logic [3:0]       DP_MASK,
`endif
    output logic [15:0]      DISPLAY
);

    localparam int CNT_W  = (SLOT_CYC > 1) ? $clog2(SLOT_CYC) : 1;
    localparam int SCNT_W = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_COMMIT
    } state_t;

    // ------------------------------------------------------------------
    // Conversion engine state
    // ------------------------------------------------------------------
    state_t              r_state;
    logic [BIN_W-1:0]    r_bin;
    logic [15:0]         r_bcd;
    logic [SCNT_W-1:0]   r_shift_cnt;
    logic                r_ovf_pend;
    logic                r_busy;
    logic                r_ovf;
    logic [15:0]         r_dig;          // committed digits, [15:12] = thousands

    // ------------------------------------------------------------------
    // Scan scheduler state
    // ------------------------------------------------------------------
    logic [CNT_W-1:0]    r_slot_cnt;
    logic [1:0]          r_slot;
    logic [15:0]         r_display;

    // Add-3 correction applied to every working nibble before each shift
    logic [15:0]         w_bcd_adj;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_adj
            assign w_bcd_adj[gi*4 +: 4] = (r_bcd[gi*4 +: 4] >= 4'd5) ?
                                          (r_bcd[gi*4 +: 4] + 4'd3) :
                                          r_bcd[gi*4 +: 4];
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= ST_IDLE;
            r_bin       <= '0;
            r_bcd       <= '0;
            r_shift_cnt <= '0;
            r_ovf_pend  <= 1'b0;
            r_busy      <= 1'b0;
            r_ovf       <= 1'b0;
            r_dig       <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (LOAD) begin
                        r_bin       <= VALUE;
                        r_bcd       <= '0;
                        r_shift_cnt <= '0;
                        r_ovf_pend  <= (32'(VALUE) > 32'd9999);
                        r_busy      <= 1'b1;
                        r_state     <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    r_bcd <= {w_bcd_adj[14:0], r_bin[BIN_W-1]};
                    r_bin <= {r_bin[BIN_W-2:0], 1'b0};
                    // A carry out of the thousands nibble can only happen for
                    // values above 9999; folding it in keeps the flag robust
                    // even if the magnitude check is ever changed.
                    r_ovf_pend <= r_ovf_pend | w_bcd_adj[15];
                    if (r_shift_cnt == SCNT_W'(BIN_W - 1)) begin
                        r_state <= ST_COMMIT;
                    end else begin
                        r_shift_cnt <= r_shift_cnt + 1'b1;
                    end
                end
                ST_COMMIT: begin
                    // All four digits and OVF change in the same edge so the
                    // scan never sees a half-updated value.
                    r_dig   <= r_bcd;
                    r_ovf   <= r_ovf_pend;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Slot scheduler: free running and independent of the converter
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_slot_cnt <= '0;
            r_slot     <= 2'd0;
        end else if (r_slot_cnt == CNT_W'(SLOT_CYC - 1)) begin
            r_slot_cnt <= '0;
            r_slot     <= r_slot + 2'd1;
        end else begin
            r_slot_cnt <= r_slot_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Display word generation
    // ------------------------------------------------------------------
    logic [1:0]  w_idx;          // digit index, 3 = thousands
    logic [3:0]  w_digit;
    logic [3:0]  w_lead_zero;    // digit and every higher digit are zero
    logic [7:0]  w_seg_base;
    logic [7:0]  w_seg;
    logic [7:0]  w_anode;
    logic        w_blank_win;
    logic        w_show;
    logic [15:0] w_display_next;

    assign w_idx = 2'd3 - r_slot;

    always_comb begin
        w_digit = r_dig[3:0];
        case (w_idx)
            2'd3:    w_digit = r_dig[15:12];
            2'd2:    w_digit = r_dig[11:8];
            2'd1:    w_digit = r_dig[7:4];
            default: w_digit = r_dig[3:0];
        endcase
    end

    always_comb begin
        w_lead_zero    = 4'b0000;
        w_lead_zero[3] = (r_dig[15:12] == 4'd0);
        w_lead_zero[2] = w_lead_zero[3] && (r_dig[11:8] == 4'd0);
        w_lead_zero[1] = w_lead_zero[2] && (r_dig[7:4] == 4'd0);
        w_lead_zero[0] = 1'b0;   // units is always shown
    end

    always_comb begin
        w_seg_base = 8'hFF;
        if (r_ovf) begin
            w_seg_base = 8'hFD;
        end else begin
            case (w_digit)
                4'd0:    w_seg_base = 8'h03;
                4'd1:    w_seg_base = 8'h9F;
                4'd2:    w_seg_base = 8'h25;
                4'd3:    w_seg_base = 8'h0D;
                4'd4:    w_seg_base = 8'h99;
                4'd5:    w_seg_base = 8'h49;
                4'd6:    w_seg_base = 8'h41;
                4'd7:    w_seg_base = 8'h1F;
                4'd8:    w_seg_base = 8'h01;
                4'd9:    w_seg_base = 8'h09;
                default: w_seg_base = 8'hFF;
            endcase
        end
    end

`ifdef DISPLAY_DP_EN
    assign w_seg = {w_seg_base[7:1], ~DP_MASK[w_idx]};
`else
    assign w_seg = w_seg_base;
`endif

    always_comb begin
        w_anode = 8'hFF;
        case (r_slot)
            2'd0:    w_anode = 8'b0111_1111;
            2'd1:    w_anode = 8'b1011_1111;
            2'd2:    w_anode = 8'b1101_1111;
            default: w_anode = 8'b1110_1111;
        endcase
    end

    assign w_blank_win    = (r_slot_cnt < CNT_W'(BLANK_CYC));
    // Leading-zero blanking does not apply to the overflow dashes.
    assign w_show         = DIG_EN[w_idx] && !w_blank_win &&
                            !(LZB && !r_ovf && w_lead_zero[w_idx]);
    assign w_display_next = w_show ? {w_seg, w_anode} : 16'hFFFF;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_display <= 16'hFFFF;
        end else begin
            r_display <= w_display_next;
        end
    end

    assign DISPLAY = r_display;
    assign BUSY    = r_busy;
    assign OVF     = r_ovf;

endmodule

// File: tb/tb_display_scan_ctrl.sv
module tb_display_scan_ctrl;

    logic        clk;
    logic        rst;
    logic [13:0] value;
    logic        load;
    logic        busy;
    logic        ovf;
    logic [3:0]  dig_en;
    logic        lzb;
    logic [15:0] display;

    int n_vec = 0;
    int n_err = 0;
    int tcyc  = 0;   // edges since reset release, tracks the DUT slot timing

    display_scan_ctrl #(
        .BIN_W     (14),
        .SLOT_CYC  (8),
        .BLANK_CYC (2)
    ) dut (
        .CLK     (clk),
        .RST     (rst),
        .VALUE   (value),
        .LOAD    (load),
        .BUSY    (busy),
        .OVF     (ovf),
        .DIG_EN  (dig_en),
        .LZB     (lzb),
        .DISPLAY (display)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) tcyc <= 0;
        else     tcyc <= tcyc + 1;
    end

    function automatic logic [7:0] anode_of(input int s);
        case (s)
            0:       return 8'h7F;
            1:       return 8'hBF;
            2:       return 8'hDF;
            default: return 8'hEF;
        endcase
    endfunction

    // Advance to a mid-slot sample (cnt=4) of the requested slot
    task automatic wait_slot(input int s, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (tcyc > 0 && ((tcyc - 1) % 8) == 4 && (((tcyc - 1) / 8) % 4) == s) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic check_frame(input string name, input logic [15:0] e0, input logic [15:0] e1,
                               input logic [15:0] e2, input logic [15:0] e3);
        logic [15:0] exp_w [4];
        logic ok;
        exp_w[0] = e0; exp_w[1] = e1; exp_w[2] = e2; exp_w[3] = e3;
        for (int s = 0; s < 4; s++) begin
            wait_slot(s, ok);
            n_vec++;
            if (!ok) begin
                n_err++;
                $display("FAIL %s slot%0d: timeout waiting for slot", name, s);
            end else if (display !== exp_w[s]) begin
                n_err++;
                $display("FAIL %s slot%0d: got %h expected %h", name, s, display, exp_w[s]);
            end
        end
        $display("frame %s checked", name);
    endtask

    task automatic do_load(input logic [13:0] v);
        @(negedge clk);
        value = v;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
        $display("load value=%0d", v);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL %s idle: got busy=%b expected 0 within 40 cycles", name, busy);
        end
    endtask

    task automatic test_reset;
        logic [15:0] exp_w;
        int cnt, slot;
        rst = 1'b1; load = 1'b0; value = '0; dig_en = 4'hF; lzb = 1'b0;
        repeat (2) @(negedge clk);
        n_vec += 3;
        if (display !== 16'hFFFF) begin n_err++; $display("FAIL reset_display: got %h expected ffff", display); end
        if (busy !== 1'b0)        begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
        if (ovf !== 1'b0)         begin n_err++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
        rst = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            cnt  = (k - 1) % 8;
            slot = ((k - 1) / 8) % 4;
            exp_w = (cnt < 2) ? 16'hFFFF : {8'h03, anode_of(slot)};
            n_vec++;
            if (display !== exp_w) begin
                n_err++;
                $display("FAIL reset_scan k=%0d: got %h expected %h", k, display, exp_w);
            end
        end
        $display("reset scan of 40 cycles checked");
    endtask

    task automatic test_convert;
        int n;
        @(negedge clk);
        value = 14'd1234;
        load  = 1'b1;
        n_vec++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL busy_before_load: got %b expected 0", busy); end
        @(negedge clk);
        load = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
        n_vec++;
        if (n != 15) begin n_err++; $display("FAIL busy_len: got %0d cycles expected 15", n); end
        n_vec++;
        if (ovf !== 1'b0) begin n_err++; $display("FAIL ovf_1234: got %b expected 0", ovf); end
        $display("load value=1234 busy=%0d cycles", n);
        check_frame("v1234", 16'h9F7F, 16'h25BF, 16'h0DDF, 16'h99EF);
    endtask

    task automatic test_lzb;
        lzb = 1'b1;
        do_load(14'd7);
        wait_idle("v7");
        check_frame("v7_lzb1", 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h1FEF);
        lzb = 1'b0;
        check_frame("v7_lzb0", 16'h037F, 16'h03BF, 16'h03DF, 16'h1FEF);
        lzb = 1'b1;
        do_load(14'd1005);
        wait_idle("v1005");
        check_frame("v1005_lzb1", 16'h9F7F, 16'h03BF, 16'h03DF, 16'h49EF);
        do_load(14'd0);
        wait_idle("v0");
        check_frame("v0_lzb1", 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h03EF);
        lzb = 1'b0;
    endtask

    task automatic test_overflow;
        do_load(14'd9999);
        wait_idle("v9999");
        n_vec++;
        if (ovf !== 1'b0) begin n_err++; $display("FAIL ovf_9999: got %b expected 0", ovf); end
        check_frame("v9999", 16'h097F, 16'h09BF, 16'h09DF, 16'h09EF);
        lzb = 1'b1;
        do_load(14'd12000);
        wait_idle("v12000");
        n_vec++;
        if (ovf !== 1'b1) begin n_err++; $display("FAIL ovf_12000: got %b expected 1", ovf); end
        check_frame("v12000", 16'hFD7F, 16'hFDBF, 16'hFDDF, 16'hFDEF);
        dig_en = 4'b0101;
        check_frame("v12000_en0101", 16'hFFFF, 16'hFDBF, 16'hFFFF, 16'hFDEF);
        dig_en = 4'hF;
        lzb = 1'b0;
    endtask

    task automatic test_back_to_back;
        do_load(14'd5678);
        repeat (2) @(negedge clk);
        value = 14'd42;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
        $display("load value=42 while busy");
        wait_idle("v5678");
        @(negedge clk);
        n_vec += 2;
        if (busy !== 1'b0) begin n_err++; $display("FAIL no_queue: got busy=%b expected 0", busy); end
        if (ovf !== 1'b0)  begin n_err++; $display("FAIL ovf_5678: got %b expected 0", ovf); end
        check_frame("v5678", 16'h497F, 16'h41BF, 16'h1FDF, 16'h01EF);
    endtask

    task automatic test_reset_abort;
        do_load(14'd9999);          // load=0 set on the negedge after the LOAD edge
        repeat (4) @(negedge clk);
        rst = 1'b1;                 // sampled on the 5th SHIFT edge
        @(negedge clk);
        n_vec += 3;
        if (busy !== 1'b0)        begin n_err++; $display("FAIL abort_busy: got %b expected 0", busy); end
        if (display !== 16'hFFFF) begin n_err++; $display("FAIL abort_display: got %h expected ffff", display); end
        if (ovf !== 1'b0)         begin n_err++; $display("FAIL abort_ovf: got %b expected 0", ovf); end
        rst = 1'b0;
        repeat (20) @(negedge clk);
        n_vec++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL abort_stays_idle: got %b expected 0", busy); end
        check_frame("abort_digits", 16'h037F, 16'h03BF, 16'h03DF, 16'h03EF);
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; value = '0; dig_en = 4'hF; lzb = 1'b0;
        test_reset();
        test_convert();
        test_lzb();
        test_overflow();
        test_back_to_back();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/display_scan_ctrl.md
Name: display_scan_ctrl

Overview:
Controller for the board's 4-digit multiplexed 7-segment display. It accepts a binary value through a load handshake and converts it to BCD with a sequential shift-add-3 FSM. It commits the digits atomically and schedules the digit scan with a programmable slot length and an anti-ghosting blanking interval. It drives the same 16-bit DISPLAY bus format used by the existing display path: {segments[7:0], anodes[7:0]}, all active-low.

Parameters:
- BIN_W, 14: width of VALUE; max displayable value is 9999.
- SLOT_CYC, 41667: CLK cycles per digit slot (50 MHz / 1200 Hz gives 300 Hz per digit).
- BLANK_CYC, 500: cycles at the start of each slot during which DISPLAY is forced to 16'hFFFF. Must be less than SLOT_CYC.

Ports:
- CLK, in, 1: system clock.
- RST, in, 1: synchronous, active-high reset.
- VALUE, in, BIN_W: binary value to display.
- LOAD, in, 1: one-cycle request to convert VALUE.
- BUSY, out, 1: conversion in progress.
- OVF, out, 1: the last committed VALUE was greater than 9999.
- DIG_EN, in, 4: per-digit enable; bit3 = thousands, bit0 = units.
- LZB, in, 1: leading-zero blanking enable.
- DISPLAY, out, 16: {seg a..g,dp ; anodes}, active-low.

Behaviour:
- Reset (synchronous, RST=1 at a CLK edge):
  - DISPLAY=16'hFFFF, BUSY=0, OVF=0.
  - Committed digits = 0,0,0,0; slot=0; slot counter=0; conversion FSM returns to IDLE.
  - A reset during a conversion aborts it; nothing is committed.
- Conversion FSM, states IDLE -> SHIFT -> COMMIT -> IDLE:
  - IDLE: LOAD=1 latches VALUE into a shift register, clears the working BCD register, sets BUSY=1 on the next edge, and enters SHIFT.
  - SHIFT: exactly BIN_W cycles. Each cycle, add 3 to every working nibble >= 5, then shift {bcd, bin} left by 1.
  - COMMIT: 1 cycle. Copies the working nibbles to the committed digit register and sets OVF = (latched VALUE > 9999).
  - On the next edge, BUSY=0 and the state is IDLE.
  - Latency: the LOAD edge to committed digits is BIN_W+2 edges; the new digits appear in the next non-blank scan window after commit.
  - LOAD while BUSY=1 is ignored (no queueing). Committed digits never show partial results.
- Overflow:
  - When OVF=1 and a slot is enabled, each digit shows a dash: segment byte 8'hFD (g only).
  - LZB does not apply.
- Scan scheduler:
  - The slot counter counts 0..SLOT_CYC-1.
  - At SLOT_CYC-1 it wraps to 0 and slot advances 0->1->2->3->0.
  - The scheduler runs independently of the conversion FSM.
- Slot-to-digit mapping (anode byte):
  - slot0 = thousands, anodes 8'b01111111.
  - slot1 = hundreds, anodes 8'b10111111.
  - slot2 = tens, anodes 8'b11011111.
  - slot3 = units, anodes 8'b11101111.
  - Anode bits [3:0] are always 1.
- DISPLAY is registered:
  - When slot counter < BLANK_CYC, DISPLAY = 16'hFFFF.
  - Otherwise, DISPLAY = {seg, anodes}.
  - If DIG_EN[digit]=0 or the digit is blanked, the whole word is 16'hFFFF (anode off).
- Segment encoding (dp=1, i.e. off):
  - 0=03, 1=9F, 2=25, 3=0D, 4=99, 5=49, 6=41, 7=1F, 8=01, 9=09.
  - Nibbles above 9 cannot occur; if one does, output 8'hFF.
- LZB=1: thousands, hundreds and tens are blanked when the digit and all higher digits are 0. Units is never blanked by LZB.
- Simultaneous events:
  - A commit landing mid-slot takes effect on the next registered DISPLAY update. Glitch-free per digit is not required, but the segment byte must never mix old and new digits.
  - RST has priority over LOAD and the scan.

Optional Feature:
- Macro: DISPLAY_DP_EN.
- When defined, adds input DP_MASK[3:0] (bit3 = thousands). The segment byte bit0 = ~DP_MASK[digit] whenever the digit is displayed, including in OVF mode.
- When undefined, the port does not exist and bit0 is always 1.

Test Plan:
- Use SLOT_CYC=8, BLANK_CYC=2 for all scenarios.
- Reset, then run 40 cycles with DIG_EN=4'hF and LZB=0 -> DISPLAY cycles 03_7F, 03_BF, 03_DF, 03_EF, each word held 6 cycles and preceded by 2 cycles of FFFF.
- VALUE=1234, LOAD pulse -> BUSY high for exactly 15 cycles (BIN_W+1 after the LOAD edge). The following scan shows 9F, 25, 0D, 99 on slots 0..3. OVF=0.
- VALUE=7 with LZB=1 -> slots 0..2 are FFFF; slot3 = 1F_EF. With LZB=0, slots 0..2 show 03.
- VALUE=12000 -> OVF=1 and all enabled slots show FD. With DIG_EN=4'b0101, slots 0 and 2 are FFFF.
- LOAD VALUE=5678, then LOAD VALUE=42 while BUSY -> second LOAD is ignored and the display shows 5678.
- LOAD VALUE=9999, assert RST at the 5th SHIFT cycle -> digits 0000, BUSY=0, DISPLAY=FFFF on the next edge.
